// File: rtl/sram1rw_ctrl_if.sv
// Core-side request/response bus of the 1RW SRAM controller.
// master = memory client, slave = controller.
interface sram1rw_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              clear_req;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready, clear_req,
      input  req_ready, resp_valid, resp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready, clear_req,
      output req_ready, resp_valid, resp_rdata, busy
   );
endinterface

// File: rtl/sram1rw_ctrl.sv
// Initiator-side controller for a 1RW SRAM macro with active-low controls:
// valid/ready requests in, ordered read responses out, plus a clear sweep.
module sram1rw_ctrl #(
   parameter int                 ADDR_W         = 10,
   parameter int                 DATA_W         = 8,
   parameter int                 RESP_DEPTH     = 2,
   parameter bit                 CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   sram1rw_ctrl_if.slave     bus,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_i,
   input  logic [DATA_W-1:0] sram_o,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb
);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic {S_RUN, S_CLEAR} state_t;
   localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

   state_t            state, state_nxt;
   logic              clr_pend, clr_pend_nxt;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
   logic              rd_pend;

   logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
   logic [PTR_W-1:0]  wptr, rptr;
   logic [CNT_W-1:0]  count;
   logic [OCC_W-1:0]  occ;
   logic              accept, push, pop, room;

   function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit check counts the read still in the macro pipe, so the FIFO
   // can never be overrun by the push one edge after accept.
   assign push   = rd_pend;
   assign pop    = (count != '0) && bus.resp_ready;
   assign occ    = OCC_W'(count) + OCC_W'(rd_pend) - OCC_W'(pop);
   assign room   = occ < OCC_W'(RESP_DEPTH);

   assign bus.req_ready  = reset_n && (state == S_RUN) && !clr_pend && room;
   assign bus.busy       = reset_n && (state == S_CLEAR);
   assign bus.resp_valid = (count != '0);
   assign bus.resp_rdata = fifo_mem[rptr];
   assign accept         = bus.req_valid && bus.req_ready;

   always_comb begin
      state_nxt    = state;
      clr_pend_nxt = clr_pend;
      clr_cnt_nxt  = clr_cnt;
      sram_a       = bus.req_addr;
      sram_i       = bus.req_wdata;
      sram_csb     = 1'b1;
      sram_web     = 1'b1;
      sram_oeb     = 1'b1;
      case (state)
         S_RUN: begin
            if (bus.clear_req) clr_pend_nxt = 1'b1;
            if (accept) begin
               sram_csb = 1'b0;
               sram_web = ~bus.req_we;
               sram_oeb = bus.req_we;
            end
            // Wait for the outstanding read to land before sweeping.
            if (clr_pend && !rd_pend) begin
               state_nxt    = S_CLEAR;
               clr_pend_nxt = 1'b0;
            end
         end
         S_CLEAR: begin
            sram_csb    = 1'b0;
            sram_web    = 1'b0;
            sram_oeb    = 1'b1;
            sram_a      = clr_cnt;
            sram_i      = CLEAR_VALUE;
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == '1) state_nxt = S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
      // Pins go idle immediately on reset, without waiting for a clock.
      if (!reset_n) begin
         sram_a   = '0;
         sram_i   = '0;
         sram_csb = 1'b1;
         sram_web = 1'b1;
         sram_oeb = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RST_STATE;
         clr_pend <= 1'b0;
         clr_cnt  <= '0;
         rd_pend  <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_pend <= clr_pend_nxt;
         clr_cnt  <= clr_cnt_nxt;
         rd_pend  <= accept && !bus.req_we;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= nxt_ptr(wptr);
         if (pop)  rptr <= nxt_ptr(rptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wptr] <= sram_o;
   end

   no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && !pop && (count == CNT_W'(RESP_DEPTH))));
endmodule

// File: tb/tb_sram1rw_ctrl.sv
// Directed bench for sram1rw_ctrl: behavioural macro model, scoreboard of
// expected read data, and a monitor that checks every response handshake.
module tb_sram1rw_ctrl;
   logic       clock;
   logic       reset_n;
   logic [9:0] sram_a;
   logic [7:0] sram_i;
   logic [7:0] sram_o;
   logic       sram_csb, sram_web, sram_oeb;

   sram1rw_ctrl_if #(.ADDR_W(10), .DATA_W(8)) bif ();

   sram1rw_ctrl #(
      .ADDR_W(10), .DATA_W(8), .RESP_DEPTH(2),
      .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)
   ) dut (
      .clock(clock), .reset_n(reset_n), .bus(bif),
      .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Macro model: pins sampled at the rising edge, read data one cycle later.
   logic [7:0] mem [1024];
   always @(posedge clock) begin
      if (!sram_csb) begin
         if (!sram_web)      mem[sram_a] <= sram_i;
         else if (!sram_oeb) sram_o      <= mem[sram_a];
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int stalls = 0;
   logic [7:0] sb [$];
   int pop_log [$];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && bif.resp_valid && bif.resp_ready) begin
         pop_log.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got 0x%0h expected no response", bif.resp_rdata);
         end else begin
            chk("resp_data", {24'h0, bif.resp_rdata}, {24'h0, sb.pop_front()});
         end
      end
   end

   task automatic idle();
      bif.req_valid = 1'b0;
   endtask

   // Holds the request until accepted; checks the macro pins on the accept cycle.
   task automatic do_req(input logic we, input logic [9:0] addr, input logic [7:0] data,
                         input logic [7:0] exp);
      bit ok = 1'b0;
      bif.req_valid = 1'b1;
      bif.req_we    = we;
      bif.req_addr  = addr;
      bif.req_wdata = data;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clock);
         ok = bif.req_ready;
         if (ok)
            chk("req_pins", {11'h0, sram_csb, sram_web, sram_oeb, sram_a, sram_i},
                {11'h0, 1'b0, ~we, we, addr, data});
         else
            stalls++;
         @(posedge clock); #1;
         if (ok && !we) sb.push_back(exp);
      end
      if (!ok) chk("req_timeout", 32'd0, 32'd1);
   endtask

   // Waits for busy, then checks every sweep cycle and the sweep length.
   task automatic sweep(input string name);
      int n = 0, bad = 0, w = 0;
      do begin
         @(negedge clock);
         w++;
      end while (!bif.busy && w < 10);
      while (bif.busy && n < 1100) begin
         if (sram_a !== n[9:0] || sram_csb !== 1'b0 || sram_web !== 1'b0 ||
             sram_oeb !== 1'b1 || sram_i !== 8'h00 || bif.req_ready !== 1'b0 ||
             bif.resp_valid !== 1'b0)
            bad++;
         n++;
         @(negedge clock);
      end
      chk({name, "_len"}, n, 1024);
      chk({name, "_pins"}, bad, 0);
      chk({name, "_ready_after"}, {30'h0, bif.req_ready, bif.busy}, 32'h2);
   endtask

   initial begin
      int acc;
      int bad;
      logic [9:0] a;
      reset_n       = 1'b0;
      bif.req_valid = 1'b1;
      bif.req_we    = 1'b1;
      bif.req_addr  = 10'h155;
      bif.req_wdata = 8'hC3;
      bif.resp_ready = 1'b1;
      bif.clear_req = 1'b0;
      #12;
      chk("rst_outputs", {27'h0, bif.resp_valid, bif.req_ready, bif.busy, 2'b00},
          32'h0);
      chk("rst_pins", {9'h0, sram_csb, sram_web, sram_oeb, sram_a, sram_i}, {9'h0, 3'b111, 18'h0});

      // 1: clear sweep after reset
      @(posedge clock); #1;
      reset_n = 1'b1;
      idle();
      sweep("t1_sweep");

      // 2: write then read 0x3FF, latency 2
      @(posedge clock); #1;
      do_req(1'b1, 10'h3FF, 8'h5A, 8'h00);
      do_req(1'b0, 10'h3FF, 8'h00, 8'h5A);
      idle();
      @(negedge clock);
      chk("t2_lat1_valid", {31'h0, bif.resp_valid}, 32'h0);
      chk("t2_idle_csb", {31'h0, sram_csb}, 32'h1);
      @(negedge clock);
      chk("t2_lat2_valid", {31'h0, bif.resp_valid}, 32'h1);
      chk("t2_lat2_data", {24'h0, bif.resp_rdata}, 32'h5A);
      @(posedge clock); #1;

      // 3: 16 writes, then 16 back-to-back reads
      for (int k = 0; k < 16; k++) do_req(1'b1, 10'(k), 8'(k), 8'h00);
      stalls = 0;
      pop_log.delete();
      for (int k = 0; k < 16; k++) do_req(1'b0, 10'(k), 8'h00, 8'(k));
      idle();
      chk("t3_stalls", stalls, 0);
      for (int k = 0; k < 30 && pop_log.size() < 16; k++) @(posedge clock);
      #1;
      chk("t3_resp_count", pop_log.size(), 16);
      if (pop_log.size() >= 16) chk("t3_resp_span", pop_log[15] - pop_log[0], 15);

      // 4: backpressure, exactly RESP_DEPTH reads accepted
      repeat (3) @(posedge clock);
      #1;
      bif.resp_ready = 1'b0;
      bif.req_valid  = 1'b1;
      bif.req_we     = 1'b0;
      a   = 10'd0;
      acc = 0;
      bif.req_addr = a;
      for (int k = 0; k < 6; k++) begin
         bit ok;
         @(negedge clock);
         ok = bif.req_ready;
         @(posedge clock); #1;
         if (ok) begin
            sb.push_back(8'(a));
            acc++;
            a = a + 10'd1;
            bif.req_addr = a;
         end
      end
      chk("t4_accepted", acc, 2);
      chk("t4_ready_low", {31'h0, bif.req_ready}, 32'h0);
      chk("t4_valid_held", {31'h0, bif.resp_valid}, 32'h1);
      chk("t4_head_stable", {24'h0, bif.resp_rdata}, 32'h0);
      bif.resp_ready = 1'b1;
      stalls = 0;
      for (int k = 2; k < 6; k++) do_req(1'b0, 10'(k), 8'h00, 8'(k));
      idle();
      chk("t4_resume_stalls", stalls, 0);
      repeat (4) @(posedge clock);
      #1;
      chk("t4_drained", sb.size(), 0);

      // 5: clear request right after a read
      do_req(1'b0, 10'd3, 8'h00, 8'h03);
      idle();
      bif.clear_req = 1'b1;
      @(posedge clock); #1;
      bif.clear_req = 1'b0;
      @(negedge clock);
      chk("t5_ready_blocked", {30'h0, bif.req_ready, bif.busy}, 32'h0);
      fork
         sweep("t5_sweep");
         begin
            repeat (20) @(posedge clock);
            #1 bif.clear_req = 1'b1;
            @(posedge clock);
            #1 bif.clear_req = 1'b0;
         end
      join
      chk("t5_old_read_done", sb.size(), 0);
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if (bif.busy !== 1'b0 || bif.req_ready !== 1'b1) bad++;
      end
      chk("t5_no_requeue", bad, 0);
      @(posedge clock); #1;
      do_req(1'b0, 10'd3, 8'h00, 8'h00);
      do_req(1'b0, 10'h3FF, 8'h00, 8'h00);
      idle();

      // 6: reset with two responses queued
      do_req(1'b1, 10'd5, 8'hA5, 8'h00);
      do_req(1'b1, 10'd6, 8'hB6, 8'h00);
      repeat (3) @(posedge clock);
      #1;
      bif.resp_ready = 1'b0;
      do_req(1'b0, 10'd5, 8'h00, 8'hA5);
      do_req(1'b0, 10'd6, 8'h00, 8'hB6);
      idle();
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("t6_queued", {31'h0, bif.resp_valid}, 32'h1);
      @(posedge clock); #3;
      bif.req_valid = 1'b1;
      bif.req_we    = 1'b0;
      bif.req_addr  = 10'd7;
      reset_n = 1'b0;
      #1;
      chk("t6_async_outputs", {28'h0, bif.resp_valid, bif.req_ready, bif.busy, 1'b0}, 32'h0);
      chk("t6_async_pins", {29'h0, sram_csb, sram_web, sram_oeb}, 32'h7);
      sb.delete();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle();
      bif.resp_ready = 1'b1;
      sweep("t6_sweep");
      bad = 0;
      repeat (4) begin
         @(negedge clock);
         if (bif.resp_valid !== 1'b0) bad++;
      end
      chk("t6_no_stale", bad, 0);
      @(posedge clock); #1;
      do_req(1'b0, 10'd5, 8'h00, 8'h00);
      idle();
      repeat (5) @(posedge clock);
      #1;
      chk("final_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1);
   end
endmodule
